// File: rtl/mux_nto1_seq_if.sv
// ----------------------------------------------------------------------------
// mux_nto1_seq_if
//
// Purpose: bundles the request side (lanes, select, mode, valid/ready) and the
// response side (registered beat, valid/last/ready, busy) of mux_nto1_seq.
//
// Signals:
//   vec      lanes, DATA_WIDTH x NUM_INPUT (unpacked [NUM_INPUT-1:0])
//   sel      lane select, direct mode only
//   mode     0 = direct, 1 = sweep
//   in_val   request valid          in_rdy   request can be accepted
//   out      registered beat data   out_val  out holds a valid beat
//   out_last final beat             out_rdy  consumer accepts the beat
//   busy     sweep in progress
//   out_err  out-of-range select flag (only with MUX_NTO1_SEQ_SEL_ERR_EN)
//
// Modports: master drives requests and consumes beats; slave is the selector.
// Optional feature macro: MUX_NTO1_SEQ_SEL_ERR_EN adds out_err.
// ----------------------------------------------------------------------------
interface mux_nto1_seq_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_INPUT  = 5,
    parameter int unsigned SEL_WIDTH  = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1
);
    logic [DATA_WIDTH-1:0] vec [NUM_INPUT-1:0];
    logic [SEL_WIDTH-1:0]  sel;
    logic                  mode;
    logic                  in_val;
    logic                  in_rdy;
    logic [DATA_WIDTH-1:0] out;
    logic                  out_val;
    logic                  out_last;
    logic                  out_rdy;
    logic                  busy;
`ifdef MUX_NTO1_SEQ_SEL_ERR_EN
    logic                  out_err;

    modport master (
        output vec, sel, mode, in_val, out_rdy,
        input  in_rdy, out, out_val, out_last, busy, out_err
    );

    modport slave (
        input  vec, sel, mode, in_val, out_rdy,
        output in_rdy, out, out_val, out_last, busy, out_err
    );
`else
    modport master (
        output vec, sel, mode, in_val, out_rdy,
        input  in_rdy, out, out_val, out_last, busy
    );

    modport slave (
        input  vec, sel, mode, in_val, out_rdy,
        output in_rdy, out, out_val, out_last, busy
    );
`endif
endinterface

// File: rtl/mux_nto1_seq.sv
// ----------------------------------------------------------------------------
// mux_nto1_seq
//
// Purpose: registered N-to-1 lane selector with a valid/ready handshake.
//   Direct mode forwards one selected lane per transaction (1-cycle latency,
//   full throughput). Sweep mode latches all lanes and streams them out in
//   lane order, one per consumed beat. out is zero whenever out_val is low.
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  synchronous, active-high reset; discards any in-flight sweep
//   bus    mux_nto1_seq_if.slave (request lanes/handshake, response beat)
//
// Optional feature macro: MUX_NTO1_SEQ_SEL_ERR_EN
//   When defined, bus.out_err flags a direct beat whose sel >= NUM_INPUT.
// ----------------------------------------------------------------------------
module mux_nto1_seq #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_INPUT  = 5,
    parameter int unsigned SEL_WIDTH  = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1
) (
    input logic          clk,
    input logic          reset,
    mux_nto1_seq_if.slave bus
);

    typedef enum logic [0:0] {
        StIdle,
        StSweep
    } state_e;

    localparam logic [SEL_WIDTH-1:0] CntLast = SEL_WIDTH'(NUM_INPUT - 1);
    localparam logic [SEL_WIDTH-1:0] CntOne  = SEL_WIDTH'(1);

    state_e                state_q, state_d;
    logic [SEL_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] buf_q [NUM_INPUT-1:0];
    logic [DATA_WIDTH-1:0] buf_d [NUM_INPUT-1:0];
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  out_val_q, out_val_d;
    logic                  out_last_q, out_last_d;
    logic                  out_err_q, out_err_d;

    logic in_rdy;
    logic accept;
    logic consume;
    logic sel_ok;

    // A new request may enter only from IDLE, and only if the output
    // register is free or is being emptied in this same cycle.
    assign in_rdy  = (state_q == StIdle) && (!out_val_q || bus.out_rdy);
    assign accept  = bus.in_val && in_rdy;
    assign consume = out_val_q && bus.out_rdy;
    assign sel_ok  = 32'(bus.sel) < NUM_INPUT;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        out_d      = out_q;
        out_val_d  = out_val_q;
        out_last_d = out_last_q;
        out_err_d  = out_err_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    out_val_d = 1'b1;
                    if (!bus.mode) begin
                        out_d      = sel_ok ? bus.vec[bus.sel] : '0;
                        out_last_d = 1'b1;
                        out_err_d  = !sel_ok;
                    end else begin
                        // Lane 0 goes straight out; the buffer feeds the rest.
                        buf_d      = bus.vec;
                        out_d      = bus.vec[0];
                        out_last_d = (NUM_INPUT == 1);
                        out_err_d  = 1'b0;
                        if (NUM_INPUT > 1) begin
                            state_d = StSweep;
                            cnt_d   = CntOne;
                        end
                    end
                end else if (consume) begin
                    out_val_d  = 1'b0;
                    out_last_d = 1'b0;
                    out_err_d  = 1'b0;
                    out_d      = '0;
                end
            end

            StSweep: begin
                if (consume) begin
                    out_d      = buf_q[cnt_q];
                    out_last_d = (cnt_q == CntLast);
                    out_err_d  = 1'b0;
                    if (cnt_q == CntLast) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            buf_q      <= '{default: '0};
            out_q      <= '0;
            out_val_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            out_q      <= out_d;
            out_val_q  <= out_val_d;
            out_last_q <= out_last_d;
            out_err_q  <= out_err_d;
        end
    end

    assign bus.in_rdy   = in_rdy;
    assign bus.out      = out_val_q ? out_q : '0;
    assign bus.out_val  = out_val_q;
    assign bus.out_last = out_last_q;
    assign bus.busy     = (state_q == StSweep);
`ifdef MUX_NTO1_SEQ_SEL_ERR_EN
    assign bus.out_err  = out_err_q;
`else
    // Without the error port an out-of-range select just yields a zero beat.
    logic unused_err;
    assign unused_err = out_err_q;
`endif

endmodule
